// File: rtl/lvt_read_steer_pkg.sv
// Shared widths and encodings for the LVT read-steering slice.
package lvt_read_steer_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int LVT_W  = 1;

  typedef enum logic [LVT_W-1:0] {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  typedef enum logic {
    CLEAR,
    READY
  } init_state_e;

endpackage

// File: rtl/lvt_read_steer_if.sv
// Read-request, bank-data, write-snoop and clear-sweep signals of lvt_read_steer.
interface lvt_read_steer_if;
  import lvt_read_steer_pkg::*;

  logic              rd_valid_i;
  logic [ADDR_W-1:0] read_addr_0, read_addr_1, read_addr_2, read_addr_3;
  logic [LVT_W-1:0]  lvt_entry_0, lvt_entry_1, lvt_entry_2, lvt_entry_3;
  logic [DATA_W-1:0] bank0_data_0, bank0_data_1, bank0_data_2, bank0_data_3;
  logic [DATA_W-1:0] bank1_data_0, bank1_data_1, bank1_data_2, bank1_data_3;
  logic              we0, we1;
  logic [ADDR_W-1:0] write_addr_0, write_addr_1;
  logic [DATA_W-1:0] write_data_0, write_data_1;
  logic              rd_valid_o;
  logic [DATA_W-1:0] read_data_0, read_data_1, read_data_2, read_data_3;
  logic              init_busy;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  modport master (
    output rd_valid_i,
    output read_addr_0, read_addr_1, read_addr_2, read_addr_3,
    output lvt_entry_0, lvt_entry_1, lvt_entry_2, lvt_entry_3,
    output bank0_data_0, bank0_data_1, bank0_data_2, bank0_data_3,
    output bank1_data_0, bank1_data_1, bank1_data_2, bank1_data_3,
    output we0, we1, write_addr_0, write_addr_1, write_data_0, write_data_1,
    input  rd_valid_o,
    input  read_data_0, read_data_1, read_data_2, read_data_3,
    input  init_busy, init_we, init_addr
  );

  modport slave (
    input  rd_valid_i,
    input  read_addr_0, read_addr_1, read_addr_2, read_addr_3,
    input  lvt_entry_0, lvt_entry_1, lvt_entry_2, lvt_entry_3,
    input  bank0_data_0, bank0_data_1, bank0_data_2, bank0_data_3,
    input  bank1_data_0, bank1_data_1, bank1_data_2, bank1_data_3,
    input  we0, we1, write_addr_0, write_addr_1, write_data_0, write_data_1,
    output rd_valid_o,
    output read_data_0, read_data_1, read_data_2, read_data_3,
    output init_busy, init_we, init_addr
  );

endinterface

// File: rtl/lvt_read_steer_read_port.sv
// One read port: stage-1 write-bypass capture, stage-2 bank/bypass steering register.
module lvt_read_port
  import lvt_read_steer_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] write_addr_0,
  input  logic [DATA_W-1:0] write_data_0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] write_addr_1,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic              load,
  input  logic [LVT_W-1:0]  lvt_entry,
  input  logic [DATA_W-1:0] bank0_data,
  input  logic [DATA_W-1:0] bank1_data,
  output logic [DATA_W-1:0] read_data
);

  logic              hit0;
  logic              hit1;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  bank_e             bank;

  always_comb begin
    hit0 = we0 && (write_addr_0 == read_addr);
    hit1 = we1 && (write_addr_1 == read_addr);
    bank = bank_e'(lvt_entry);
  end

  // Write port 1 wins a same-address collision, mirroring the LVT's own ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= hit0 || hit1;
      byp_data <= hit1 ? write_data_1 : write_data_0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data <= '0;
    end else if (load) begin
      if (byp_hit)
        read_data <= byp_data;
      else if (bank == BANK_1)
        read_data <= bank1_data;
      else
        read_data <= bank0_data;
    end
  end

endmodule

// File: rtl/lvt_read_steer.sv
// Read-side steering for a 2W/4R LVT register file, with post-reset clear sweep.
module lvt_read_steer
  import lvt_read_steer_pkg::*;
(
  input logic             clock,
  input logic             reset_n,
  lvt_read_steer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  init_state_e       state;
  logic [ADDR_W-1:0] count;
  logic              busy_q;
  logic              we_q;
  logic              valid_s1;
  logic              valid_s2;

  logic [ADDR_W-1:0] raddr [4];
  logic [LVT_W-1:0]  lvt   [4];
  logic [DATA_W-1:0] b0    [4];
  logic [DATA_W-1:0] b1    [4];
  logic [DATA_W-1:0] rdata [4];

  assign raddr[0] = bus.read_addr_0;
  assign raddr[1] = bus.read_addr_1;
  assign raddr[2] = bus.read_addr_2;
  assign raddr[3] = bus.read_addr_3;
  assign lvt[0]   = bus.lvt_entry_0;
  assign lvt[1]   = bus.lvt_entry_1;
  assign lvt[2]   = bus.lvt_entry_2;
  assign lvt[3]   = bus.lvt_entry_3;
  assign b0[0]    = bus.bank0_data_0;
  assign b0[1]    = bus.bank0_data_1;
  assign b0[2]    = bus.bank0_data_2;
  assign b0[3]    = bus.bank0_data_3;
  assign b1[0]    = bus.bank1_data_0;
  assign b1[1]    = bus.bank1_data_1;
  assign b1[2]    = bus.bank1_data_2;
  assign b1[3]    = bus.bank1_data_3;

  // The counter doubles as init_addr; it is parked at 0 on leaving CLEAR.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= CLEAR;
      count    <= '0;
      busy_q   <= 1'b1;
      we_q     <= 1'b1;
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s1 <= bus.rd_valid_i && !busy_q;
      valid_s2 <= valid_s1;
      case (state)
        CLEAR: begin
          if (count == LAST_ADDR) begin
            state  <= READY;
            count  <= '0;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        READY: state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_port
    lvt_read_port u_port (
      .clock        (clock),
      .reset_n      (reset_n),
      .read_addr    (raddr[k]),
      .we0          (bus.we0),
      .write_addr_0 (bus.write_addr_0),
      .write_data_0 (bus.write_data_0),
      .we1          (bus.we1),
      .write_addr_1 (bus.write_addr_1),
      .write_data_1 (bus.write_data_1),
      .load         (valid_s1),
      .lvt_entry    (lvt[k]),
      .bank0_data   (b0[k]),
      .bank1_data   (b1[k]),
      .read_data    (rdata[k])
    );
  end

  assign bus.read_data_0 = rdata[0];
  assign bus.read_data_1 = rdata[1];
  assign bus.read_data_2 = rdata[2];
  assign bus.read_data_3 = rdata[3];
  assign bus.rd_valid_o  = valid_s2;
  assign bus.init_busy   = busy_q;
  assign bus.init_we     = we_q;
  assign bus.init_addr   = count;

endmodule

// File: tb/tb_lvt_read_steer.sv
// Scoreboard bench for lvt_read_steer with a behavioural LVT + two-bank register file.
module tb_lvt_read_steer;
  import lvt_read_steer_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lvt_read_steer_if bus ();

  lvt_read_steer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int run = 0;
  int max_run = 0;
  logic [3:0][31:0] expq [$];

  // Behavioural register file: registered reads, init sweep muxed onto write port 0.
  logic        lvt_m [0:15];
  logic [31:0] b0_m  [0:15];
  logic [31:0] b1_m  [0:15];

  initial begin
    for (int i = 0; i < 16; i++) begin
      lvt_m[i] = 1'b0;
      b0_m[i]  = '0;
      b1_m[i]  = '0;
    end
  end

  always @(posedge clock) begin
    bus.lvt_entry_0  <= lvt_m[bus.read_addr_0];
    bus.lvt_entry_1  <= lvt_m[bus.read_addr_1];
    bus.lvt_entry_2  <= lvt_m[bus.read_addr_2];
    bus.lvt_entry_3  <= lvt_m[bus.read_addr_3];
    bus.bank0_data_0 <= b0_m[bus.read_addr_0];
    bus.bank0_data_1 <= b0_m[bus.read_addr_1];
    bus.bank0_data_2 <= b0_m[bus.read_addr_2];
    bus.bank0_data_3 <= b0_m[bus.read_addr_3];
    bus.bank1_data_0 <= b1_m[bus.read_addr_0];
    bus.bank1_data_1 <= b1_m[bus.read_addr_1];
    bus.bank1_data_2 <= b1_m[bus.read_addr_2];
    bus.bank1_data_3 <= b1_m[bus.read_addr_3];
    if (bus.init_we) begin
      b0_m[bus.init_addr]  <= '0;
      lvt_m[bus.init_addr] <= 1'b0;
    end else if (bus.we0) begin
      b0_m[bus.write_addr_0]  <= bus.write_data_0;
      lvt_m[bus.write_addr_0] <= 1'b0;
    end
    if (bus.we1) begin
      b1_m[bus.write_addr_1]  <= bus.write_data_1;
      lvt_m[bus.write_addr_1] <= 1'b1;
    end
  end

  always @(negedge clock) begin
    logic [3:0][31:0] e;
    logic [3:0][31:0] got;
    if (bus.rd_valid_o === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rd_valid_o=1, required no pending read");
      end else begin
        e = expq.pop_front();
        got = {bus.read_data_3, bus.read_data_2, bus.read_data_1, bus.read_data_0};
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (got[k] !== e[k]) begin
            errors++;
            $display("FAIL read_data_%0d: got %h required %h", k, got[k], e[k]);
          end
        end
      end
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] a0, a1, a2, a3,
                      input logic w0, input logic [3:0] wa0, input logic [31:0] wd0,
                      input logic w1, input logic [3:0] wa1, input logic [31:0] wd1,
                      input logic rv, input logic [31:0] e0, e1, e2, e3);
    bus.read_addr_0 = a0;  bus.read_addr_1 = a1;
    bus.read_addr_2 = a2;  bus.read_addr_3 = a3;
    bus.we0 = w0;  bus.write_addr_0 = wa0;  bus.write_data_0 = wd0;
    bus.we1 = w1;  bus.write_addr_1 = wa1;  bus.write_data_1 = wd1;
    bus.rd_valid_i = rv;
    if (rv) expq.push_back({e3, e2, e1, e0});
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_valid", 32'(bus.rd_valid_o), 0);
    chk("rst_read_data_0", bus.read_data_0, 0);
    chk("rst_read_data_1", bus.read_data_1, 0);
    chk("rst_read_data_2", bus.read_data_2, 0);
    chk("rst_read_data_3", bus.read_data_3, 0);
  endtask

  // Starts at the first negedge after reset release; reads are requested throughout.
  task automatic sweep_check();
    bus.rd_valid_i = 1'b1;
    bus.read_addr_0 = 4'd4; bus.read_addr_1 = 4'd4;
    bus.read_addr_2 = 4'd4; bus.read_addr_3 = 4'd4;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy", 32'(bus.init_busy), 1);
      chk("sweep_we", 32'(bus.init_we), 1);
      chk("sweep_addr", 32'(bus.init_addr), i);
      chk("sweep_rd_valid", 32'(bus.rd_valid_o), 0);
      @(negedge clock);
    end
    bus.rd_valid_i = 1'b0;
    chk("ready_busy", 32'(bus.init_busy), 0);
    chk("ready_we", 32'(bus.init_we), 0);
    chk("ready_addr", 32'(bus.init_addr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.rd_valid_i = 0;
    bus.read_addr_0 = 0; bus.read_addr_1 = 0; bus.read_addr_2 = 0; bus.read_addr_3 = 0;
    bus.we0 = 0; bus.we1 = 0;
    bus.write_addr_0 = 0; bus.write_addr_1 = 0;
    bus.write_data_0 = 0; bus.write_data_1 = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs();
    reset_n = 1'b1;
    sweep_check();

    // First READY cycle is serviced; bank 0 was just cleared.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Preload through the write ports.
    step(0, 0, 0, 0, 1, 4'd0, 32'h0A0A0A0A, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 32'h1B1B1B1B, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd2, 32'h22222222, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd7, 32'h00000007, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Bank steering: reg 3 lives in bank 1.
    step(3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 1,
         32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(2);

    // Bypass priority, then port-0-only bypass, then plain read of the result.
    step(5, 5, 5, 5, 1, 4'd5, 32'hAAAA0000, 1, 4'd5, 32'hBBBB0000, 1,
         32'hBBBB0000, 32'hBBBB0000, 32'hBBBB0000, 32'hBBBB0000);
    step(5, 6, 5, 5, 1, 4'd5, 32'hAAAA0000, 0, 0, 0, 1,
         32'hAAAA0000, 32'h0, 32'hAAAA0000, 32'hAAAA0000);
    step(5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 1,
         32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000);
    idle(2);

    // A write one cycle after the read is not visible; a read in the write cycle is.
    step(7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 1, 32'h7, 32'h7, 32'h7, 32'h7);
    step(7, 7, 7, 7, 1, 4'd7, 32'h77, 0, 0, 0, 1, 32'h77, 32'h77, 32'h77, 32'h77);
    step(7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 1, 32'h77, 32'h77, 32'h77, 32'h77);
    idle(3);

    // Back-to-back streaming with rotating bank mixes.
    max_run = 0;
    step(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1,
         32'h0A0A0A0A, 32'h1B1B1B1B, 32'h22222222, 32'hDEADBEEF);
    step(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1,
         32'h1B1B1B1B, 32'h22222222, 32'hDEADBEEF, 32'h0A0A0A0A);
    step(2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1,
         32'h22222222, 32'hDEADBEEF, 32'h0A0A0A0A, 32'h1B1B1B1B);
    step(3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1,
         32'hDEADBEEF, 32'h0A0A0A0A, 32'h1B1B1B1B, 32'h22222222);
    idle(3);
    chk("stream_run", 32'(max_run), 4);

    // Port-1 bypass seen only by the ports that match.
    step(2, 3, 2, 0, 0, 0, 0, 1, 4'd2, 32'h2B2B2B2B, 1,
         32'h2B2B2B2B, 32'hDEADBEEF, 32'h2B2B2B2B, 32'h0A0A0A0A);
    idle(3);

    // In-flight read dropped by reset; outputs cleared.
    step(3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.rd_valid_i = 1'b1;
    @(negedge clock);
    bus.rd_valid_i = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset_outputs();
    reset_n = 1'b1;

    // Reset again at sweep address 9.
    n = 0;
    while (bus.init_addr !== 4'd9 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("reach_addr9", 32'(bus.init_addr), 9);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 32'(bus.init_busy), 1);
    chk("midrst_we", 32'(bus.init_we), 1);
    chk("midrst_addr", 32'(bus.init_addr), 0);
    chk_reset_outputs();
    reset_n = 1'b1;
    sweep_check();

    // Every LVT entry now points at the cleared bank 0.
    step(3, 1, 2, 7, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(3);
    chk("queue_empty", 32'(expq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
